// File: rtl/dvp_grb_pkg.sv
// dvp_grb_pkg: register map, CTRL/STATUS bit positions, capture FSM
// encoding and the FIFO word layout shared by the frame-grabber write stage.
package dvp_grb_pkg;

  // Word offsets, compared against addr[11:2]
  localparam logic [9:0] REG_CTRL   = 10'h000;
  localparam logic [9:0] REG_STATUS = 10'h001;
  localparam logic [9:0] REG_BASE   = 10'h002;
  localparam logic [9:0] REG_STRIDE = 10'h003;

  // CTRL bits
  localparam int CTRL_START   = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_ABORT   = 2;
  localparam int CTRL_TESTPAT = 3;

  // STATUS bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_OVF      = 1;
  localparam int STAT_SHORT    = 2;
  localparam int STAT_FCNT_LSB = 16;
  localparam int FCNT_W        = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } grb_state_e;

  // One FIFO entry: destination byte address plus packed pixel pair
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } grb_word_t;

endpackage

// File: rtl/grb_fifo.sv
// grb_fifo: synchronous word FIFO. The head entry is presented on dout
// without a read request (first-word-fall-through) and stays stable until
// popped. A push into a full FIFO is taken only when a pop happens in the
// same cycle; flush empties it in one cycle.
module grb_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rp_q];

  // Storage array; no reset needed, contents are qualified by cnt_q
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dvp_grb.sv
// dvp_grb: frame-grabber write stage. Packs 16-bit DVP pixel pairs into
// 32-bit words tagged with their destination byte address, queues them in
// grb_fifo and hands them to the memory writer over a valid/ready port.
// Optional build macro DVP_GRB_TESTPAT_EN adds CTRL bit3 TESTPAT, which
// replaces each accepted pixel by {line[7:0], col[7:0]}.
module dvp_grb
  import dvp_grb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic [11:0]      addr,
  input  logic             cs,
  input  logic             wr,
  input  logic [31:0]      wrdata,
  output logic [31:0]      rddata,
  input  logic [10:0]      hgt,
  input  logic [10:0]      wdt,
  input  logic             pix_vsync,
  input  logic             pix_href,
  input  logic             pix_de,
  input  logic [PIX_W-1:0] pix_data,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic             done,
  output logic             busy
);

  // ---------------------------------------------------------------- registers
  logic        cont_q;
  logic [28:0] base_q;
  logic [13:0] stride_q;
  logic        testpat;
  logic        wr_ctrl, start_p, abort_p;

  assign wr_ctrl = cs & wr & (addr[11:2] == REG_CTRL);
  assign start_p = wr_ctrl & wrdata[CTRL_START];
  assign abort_p = wr_ctrl & wrdata[CTRL_ABORT];

`ifdef DVP_GRB_TESTPAT_EN
  logic testpat_q;
  // Test-pattern enable lives alongside CONT in CTRL
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)  testpat_q <= 1'b0;
    else if (wr_ctrl)  testpat_q <= wrdata[CTRL_TESTPAT];
  end
  assign testpat = testpat_q;
`else
  assign testpat = 1'b0;
`endif

  // Writable configuration; START/ABORT are pulses decoded from the write
  // itself, so they never hold state and always read back as 0
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cont_q   <= 1'b0;
      base_q   <= '0;
      stride_q <= '0;
    end else if (cs & wr) begin
      case (addr[11:2])
        REG_CTRL:   cont_q   <= wrdata[CTRL_CONT];
        REG_BASE:   base_q   <= wrdata[31:3];
        REG_STRIDE: stride_q <= wrdata[15:2];
        default:    ;
      endcase
    end
  end

  // -------------------------------------------------------------- edge detect
  logic vs_q, href_q;
  logic vs_rise;

  // One-cycle history of vsync/href for edge detection
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      vs_q   <= 1'b0;
      href_q <= 1'b0;
    end else begin
      vs_q   <= pix_vsync;
      href_q <= pix_href;
    end
  end

  assign vs_rise = pix_vsync & ~vs_q;

  // ------------------------------------------------------------- capture path
  grb_state_e  state_q;
  logic        busy_q, done_q, ovf_q, short_q;
  logic [FCNT_W-1:0] fcnt_q;

  logic [10:0] col_q, line_cnt_q;
  logic [31:0] line_addr_q;
  logic [15:0] hold_q;

  logic        capture, frame_start, accept, line_end, last_line, geom_zero;
  logic [15:0] pix_v;
  logic [31:0] col_off, stride_ext;
  logic        push_d;
  grb_word_t   push_word_d, head;
  logic        fifo_full, fifo_empty, fifo_pop, ovf_set;

  assign capture     = (state_q == ST_CAPTURE);
  assign frame_start = (state_q == ST_WAIT_VS) & vs_rise;
  assign accept      = capture & pix_href & pix_de & (col_q < wdt) & ~abort_p;
  assign line_end    = capture & href_q & ~pix_href;
  assign last_line   = (({1'b0, line_cnt_q} + 12'd1) >= {1'b0, hgt});
  assign geom_zero   = (hgt == '0) | (wdt == '0);
  assign pix_v       = testpat ? {line_cnt_q[7:0], col_q[7:0]} : pix_data;
  assign col_off     = {20'h0, col_q[10:1], 2'b00};
  assign stride_ext  = {16'h0, stride_q, 2'b00};

  // A word completes on an odd-column pixel, or at line end when the line
  // stopped on an even column and a lone pixel is still held
  assign push_d           = ((accept | (line_end & ~abort_p)) & col_q[0]);
  assign push_word_d.addr = line_addr_q + col_off;
  assign push_word_d.data = line_end ? {16'h0, hold_q} : {pix_v, hold_q};

  assign fifo_pop = mem_valid & mem_ready;
  assign ovf_set  = push_d & fifo_full & ~fifo_pop;

  // Column/line counters, pixel holding register and accumulated line address
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      col_q       <= '0;
      line_cnt_q  <= '0;
      line_addr_q <= '0;
      hold_q      <= '0;
    end else if (frame_start) begin
      col_q       <= '0;
      line_cnt_q  <= '0;
      line_addr_q <= {base_q, 3'b000};
    end else if (accept) begin
      col_q <= col_q + 11'd1;
      if (!col_q[0]) hold_q <= pix_v;
    end else if (line_end) begin
      col_q       <= '0;
      line_cnt_q  <= line_cnt_q + 11'd1;
      line_addr_q <= line_addr_q + stride_ext;
    end
  end

  // Frame sequencing with registered done/busy, sticky status and frame count
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (ovf_set) ovf_q <= 1'b1;
      if (abort_p) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start_p) begin
            state_q <= ST_WAIT_VS;
            busy_q  <= 1'b1;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
          end
          // Empty geometry skips capture entirely and just reports completion
          ST_WAIT_VS: if (vs_rise) state_q <= geom_zero ? ST_DRAIN : ST_CAPTURE;
          ST_CAPTURE: begin
            if (vs_rise) begin
              state_q <= ST_DRAIN;
              short_q <= 1'b1;
            end else if (line_end && last_line) begin
              state_q <= ST_DRAIN;
            end
          end
          ST_DRAIN: if (fifo_empty) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
          ST_DONE: begin
            fcnt_q <= fcnt_q + 1'b1;
            if (cont_q) state_q <= ST_WAIT_VS;
            else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  grb_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .push  (push_d),
    .pop   (fifo_pop),
    .flush (abort_p),
    .din   (push_word_d),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs are forced to 0 while nothing is valid so stale storage never shows
  assign mem_valid = ~fifo_empty;
  assign mem_addr  = mem_valid ? head.addr : 32'h0;
  assign mem_data  = mem_valid ? head.data : 32'h0;
  assign done      = done_q;
  assign busy      = busy_q;

  // ---------------------------------------------------------------- read mux
  // Register read-back, purely combinational from addr
  always_comb begin
    rddata = 32'h0;
    case (addr[11:2])
      REG_CTRL: begin
        rddata[CTRL_CONT]    = cont_q;
        rddata[CTRL_TESTPAT] = testpat;
      end
      REG_STATUS: begin
        rddata[STAT_BUSY]                  = busy_q;
        rddata[STAT_OVF]                   = ovf_q;
        rddata[STAT_SHORT]                 = short_q;
        rddata[STAT_FCNT_LSB +: FCNT_W]    = fcnt_q;
      end
      REG_BASE:   rddata = {base_q, 3'b000};
      REG_STRIDE: rddata = {16'h0, stride_q, 2'b00};
      default:    rddata = 32'h0;
    endcase
  end

  // Byte-lane and high write-data bits that no register consumes
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wrdata};

endmodule

// File: doc/dvp_grb.md
Name: dvp_grb

Overview:
- Frame-grabber write stage that sits directly downstream of the AXI-lite register block and shares its clock and reset.
- Slave on one chip-select of the internal register bus. Consumes the hgt/wdt frame geometry and a 16-bit DVP-style pixel stream already synchronised to the clock.
- Packs pixel pairs into 32-bit words, buffers them in a small FIFO and presents them with destination addresses to a downstream memory writer.
- Pulses done when a frame completes; this pulse drives the grb_l_done/grb_r_done interrupt input.

Parameters:
FIFO_DEPTH, 16, word FIFO entries (power of 2, >=4)
PIX_W, 16, pixel width (fixed at 16; two pixels per word)

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
addr  in  12  internal bus byte address
cs  in  1  chip-select for this block
wr  in  1  write strobe; write occurs when cs&wr
wrdata  in  32  write data
rddata  out  32  read data, combinational from addr
hgt  in  11  frame height in lines
wdt  in  11  frame width in pixels
pix_vsync  in  1  frame sync, rising edge = frame start
pix_href  in  1  line active
pix_de  in  1  pixel valid qualifier
pix_data  in  16  pixel
mem_valid  out  1  word available
mem_ready  in  1  writer accepts word
mem_addr  out  32  byte address of word
mem_data  out  32  {pixel odd, pixel even}
done  out  1  one-cycle frame-complete pulse
busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; registers 0.
- Registers, selected by addr[11:2]:
  - 0x000 CTRL: bit0 START (write-1, self-clearing, reads 0); bit1 CONT (continuous); bit2 ABORT (write-1, self-clearing).
  - 0x001 STATUS (RO): bit0 busy; bit1 overflow (sticky); bit2 short_frame (sticky); [27:16] frame_cnt (wraps at 4095).
  - 0x002 BASE: [31:3] writable, [2:0] read 0.
  - 0x003 STRIDE: [15:2] writable.
  - Unmapped offsets read 0.
- Sticky status bits clear on START.
- FSM states:
  - IDLE -> WAIT_VS on START.
  - WAIT_VS -> CAPTURE on vsync rising edge (vsync registered once; edge = vs & ~vs_r). Line counter and address clear here.
  - CAPTURE -> DRAIN when line_cnt reaches hgt, or on an early vsync rising edge (also sets short_frame).
  - DRAIN -> DONE when FIFO empty and no handshake is pending.
  - DONE: done=1 for one cycle; frame_cnt+1; next state WAIT_VS if CONT, else IDLE.
  - ABORT in any state -> IDLE next cycle. FIFO flushes, mem_valid drops, no done pulse.
- Pixel accepted when CAPTURE & href & de & col < wdt; pixels beyond wdt are ignored.
  - Even column goes to the low half of a holding register; odd column completes the word and pushes it to the FIFO.
- Line end = href falling edge. If the column count is odd, push {16'h0, held pixel}. line_cnt+1; line address += STRIDE.
- Word address = BASE + line*STRIDE + (col>>1)*4. Line address is accumulated, with no multiplier.
- hgt=0 or wdt=0: START goes straight through WAIT_VS -> DRAIN -> DONE at the first vsync, with no words written.
- FIFO full on push: word dropped, overflow set, capture continues.
- Output handshake is AXI-stream style:
  - mem_valid = FIFO not empty.
  - Pop on mem_valid & mem_ready.
  - mem_addr/mem_data stay stable while valid & ~ready.
- Simultaneous push and pop on a full FIFO is legal, with no overflow.
- START while busy is ignored. A register write and a self-clear in the same cycle: the write wins.

Optional Feature:
- Macro DVP_GRB_TESTPAT_EN.
- Defined: CTRL bit3 TESTPAT is writable. When it is 1, each accepted pixel is replaced by {line_cnt[7:0], col[7:0]}, so a known image exists without a sensor.
- Not defined: bit3 reads 0 and pixel data passes through unchanged.

Decomposition:
- Package dvp_grb_pkg:
  - register offsets (CTRL/STATUS/BASE/STRIDE)
  - CTRL and STATUS bit indices
  - FSM state encoding (IDLE, WAIT_VS, CAPTURE, DRAIN, DONE)
- Sub-module grb_fifo: synchronous FIFO with width 64 ({addr, data}) and depth FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty; output register is first-word-fall-through.

Test Plan:
- Reset with pixels toggling -> mem_valid=0, done=0, rddata at 0x004 = 0.
- BASE=0x1000, STRIDE=8, hgt=2, wdt=4, START, mem_ready=1, pixels 0x0001..0x0008 -> 4 words:
  - 0x1000:0x00020001
  - 0x1004:0x00040003
  - 0x1008:0x00060005
  - 0x100C:0x00080007
  - then one done pulse; frame_cnt=1.
- wdt=3, hgt=1 -> words 0x00020001 then 0x00000003; a 4th pixel on the line is ignored.
- mem_ready=0 for a full frame with FIFO_DEPTH=4, 6 words -> first 4 words kept, overflow=1, then drained in order after ready=1.
- CONT=1, hgt=1, then vsync arrives mid-line of frame 2 with hgt=2 -> short_frame=1, done pulses twice, FSM returns to WAIT_VS.
- ABORT during CAPTURE with FIFO holding 3 words -> next cycle mem_valid=0, busy=0, no done pulse.
